// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forward-select encoding, register index
// width and the shadow stage-tag layout used by the hazard controller
// and the datapath forwarding muxes.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    // Forward-select encoding shared with the datapath 3:1 muxes.
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Load-use stall sequencer states.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // Per-stage destination tag of an in-flight instruction.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
    } stage_tag_t;

    // EX additionally remembers its own sources for the forward compare.
    typedef struct packed {
        stage_tag_t            tag;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rt;
    } ex_tag_t;

    // A stage can supply a value for register r only if it really writes
    // it; $0 is hard-wired zero and is never a forwarding source.
    function automatic logic tag_hits(stage_tag_t t, logic [REG_ADDR_W-1:0] r);
        return t.valid && t.reg_write && (t.dest != '0) && (t.dest == r);
    endfunction

endpackage

// File: rtl/fwd_sel_gen.sv
// One forward-select comparator: picks the youngest in-flight producer
// of a source register, or the register file when none matches.
module fwd_sel_gen
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  uses_i,
    input  stage_tag_t            mem_tag_i,
    input  stage_tag_t            wb_tag_i,
    output logic [1:0]            sel_o
);

    // The load flag only matters for hazard detection, not forwarding.
    logic unused_mem_read;
    assign unused_mem_read = mem_tag_i.mem_read ^ wb_tag_i.mem_read;

    // EX/MEM is checked first so the youngest producer wins.
    always_comb begin
        sel_o = FWD_REG;
        if (uses_i) begin
            if (tag_hits(mem_tag_i, src_i)) begin
                sel_o = FWD_EXMEM;
            end else if (tag_hits(wb_tag_i, src_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for the 5-stage pipeline.
// Shadows the EX, MEM and WB destination tags, drives the ALU operand
// forward selects from those registered tags and sequences load-use stalls.
// REG_ADDR_W must match the package width since the stage tags use it.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W       = pipe_pkg::REG_ADDR_W,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_in,
    input  logic [REG_ADDR_W-1:0] id_rs_in,
    input  logic [REG_ADDR_W-1:0] id_rt_in,
    input  logic                  id_uses_rt_in,
    input  logic [REG_ADDR_W-1:0] id_dest_in,
    input  logic                  id_reg_write_in,
    input  logic                  id_mem_read_in,
    input  logic                  flush_in,
    output logic [1:0]            fwd_a_out,
    output logic [1:0]            fwd_b_out,
    output logic                  stall_out,
    output logic [CNT_W-1:0]      stall_count_out
);

    import pipe_pkg::*;

    // LOAD_USE_BUBBLES is at most 3, so two bits hold the remaining count.
    localparam int BUB_W = 2;

    ex_tag_t          ex_q, ex_d;
    stage_tag_t       mem_q;
    stage_tag_t       wb_q;
    logic [0:0]       state_q, state_d;
    logic [BUB_W-1:0] bub_q, bub_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             hazard;
    logic             stall;

    logic [REG_ADDR_W-1:0] sel_src [2];
    logic                  sel_uses [2];
    logic [1:0]            sel_out [2];

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        hazard = id_valid_in && !flush_in
              && ex_q.tag.valid && ex_q.tag.mem_read && (ex_q.tag.dest != '0)
              && ((ex_q.tag.dest == id_rs_in)
                  || (id_uses_rt_in && (ex_q.tag.dest == id_rt_in)));
    end

    // Stall sequencer: the first bubble comes straight from the hazard,
    // extra bubbles are counted down in STALL; a flush aborts everything.
    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        stall   = 1'b0;
        if (flush_in) begin
            state_d = ST_IDLE;
            bub_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stall = hazard;
                    if (hazard && (LOAD_USE_BUBBLES > 1)) begin
                        state_d = ST_STALL;
                        bub_d   = BUB_W'(LOAD_USE_BUBBLES - 1);
                    end
                end
                ST_STALL: begin
                    stall = 1'b1;
                    if (bub_q <= BUB_W'(1)) begin
                        state_d = ST_IDLE;
                        bub_d   = '0;
                    end else begin
                        bub_d = bub_q - BUB_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    bub_d   = '0;
                end
            endcase
        end
    end

    // Next EX tag: the ID instruction, or a bubble when stalled/flushed/empty.
    always_comb begin
        ex_d.tag.valid     = id_valid_in && !stall && !flush_in;
        ex_d.tag.dest      = id_dest_in;
        ex_d.tag.reg_write = id_reg_write_in;
        ex_d.tag.mem_read  = id_mem_read_in;
        ex_d.rs            = id_rs_in;
        ex_d.rt            = id_rt_in;
        ex_d.uses_rt       = id_uses_rt_in;
    end

    // Shadow pipeline, stall sequencer and stall performance counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= ST_IDLE;
            bub_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q.tag;
            wb_q    <= mem_q;
            state_q <= state_d;
            bub_q   <= bub_d;
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Operand A compares against rs; operand B against rt only when read.
    always_comb begin
        sel_src[0]  = ex_q.rs;
        sel_uses[0] = ex_q.tag.valid;
        sel_src[1]  = ex_q.rt;
        sel_uses[1] = ex_q.tag.valid && ex_q.uses_rt;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sel
            fwd_sel_gen u_sel (
                .src_i     (sel_src[gi]),
                .uses_i    (sel_uses[gi]),
                .mem_tag_i (mem_q),
                .wb_tag_i  (wb_q),
                .sel_o     (sel_out[gi])
            );
        end
    endgenerate

    assign fwd_a_out       = sel_out[0];
    assign fwd_b_out       = sel_out[1];
    assign stall_out       = stall;
    assign stall_count_out = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: two instances (1 and 3 load-use bubbles)
// share one ID stream; a queue-based scoreboard checks every cycle against
// an instruction-history reference model, plus pinned directed checks.
module tb_fwd_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       id_valid, id_ut, id_rw, id_mr, flush;
    logic [4:0] id_rs, id_rt, id_dest;

    logic [1:0]  fa1, fb1, fa3, fb3;
    logic        st1, st3;
    logic [31:0] sc1, sc3;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(1), .CNT_W(32)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid_in(id_valid), .id_rs_in(id_rs),
        .id_rt_in(id_rt), .id_uses_rt_in(id_ut), .id_dest_in(id_dest),
        .id_reg_write_in(id_rw), .id_mem_read_in(id_mr), .flush_in(flush),
        .fwd_a_out(fa1), .fwd_b_out(fb1), .stall_out(st1), .stall_count_out(sc1));

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(3), .CNT_W(32)) u3 (
        .clk(clk), .rst_n(rst_n), .id_valid_in(id_valid), .id_rs_in(id_rs),
        .id_rt_in(id_rt), .id_uses_rt_in(id_ut), .id_dest_in(id_dest),
        .id_reg_write_in(id_rw), .id_mem_read_in(id_mr), .flush_in(flush),
        .fwd_a_out(fa3), .fwd_b_out(fb3), .stall_out(st3), .stall_count_out(sc3));

    // One instruction as seen by the model.
    typedef struct {
        bit v; int rs; int rt; bit ut; int dest; bit rw; bit mr;
    } ins_t;

    typedef struct {
        int k; bit [1:0] a; bit [1:0] b; bit s; bit [31:0] c; int cyc;
    } exp_t;

    // Model state per instance: instructions occupying EX(0), MEM(1), WB(2).
    ins_t      hist [2][3];
    int        rem_m [2];
    bit [31:0] cnt_m [2];
    int        lub [2] = '{1, 3};
    exp_t      sbq [$];
    int        total = 0;
    int        bad = 0;
    int        cyc = 0;

    function automatic ins_t mk(bit v, int rs, int rt, bit ut, int dest, bit rw, bit mr);
        ins_t i;
        i.v = v; i.rs = rs; i.rt = rt; i.ut = ut; i.dest = dest; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic ins_t rtype(int rd, int rs, int rt);
        return mk(1, rs, rt, 1, rd, 1, 0);
    endfunction

    function automatic ins_t lw(int rt, int base);
        return mk(1, base, rt, 0, rt, 1, 1);
    endfunction

    function automatic ins_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0);
    endfunction

    // An older instruction supplies r if it writes a nonzero register r.
    function automatic bit produces(ins_t p, int r);
        return p.v && p.rw && (p.dest != 0) && (p.dest == r);
    endfunction

    function automatic bit [1:0] pick(ins_t m, ins_t w, int r, bit used);
        if (!used) return 2'd0;
        if (produces(m, r)) return 2'd2;
        if (produces(w, r)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) hist[k][s] = nop();
            rem_m[k] = 0;
            cnt_m[k] = 0;
        end
    endtask

    task automatic drive_ids(ins_t id, bit fl);
        id_valid = id.v;
        id_rs    = 5'(id.rs);
        id_rt    = 5'(id.rt);
        id_ut    = id.ut;
        id_dest  = 5'(id.dest);
        id_rw    = id.rw;
        id_mr    = id.mr;
        flush    = fl;
    endtask

    // One pipeline cycle: drive ID, push expected outputs, advance model.
    task automatic step(ins_t id, bit fl);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_ids(id, fl);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            ins_t ex;
            bit   hz, stl;
            exp_t e;
            ex  = hist[k][0];
            hz  = id.v && !fl && ex.v && ex.mr && (ex.dest != 0)
               && ((ex.dest == id.rs) || (id.ut && (ex.dest == id.rt)));
            stl = fl ? 1'b0 : ((rem_m[k] > 0) ? 1'b1 : hz);
            e.k   = k;
            e.a   = pick(hist[k][1], hist[k][2], ex.rs, ex.v);
            e.b   = pick(hist[k][1], hist[k][2], ex.rt, ex.v && ex.ut);
            e.s   = stl;
            e.c   = cnt_m[k];
            e.cyc = cyc;
            sbq.push_back(e);
            cnt_m[k] = cnt_m[k] + 32'(stl);
            if (fl) rem_m[k] = 0;
            else if (rem_m[k] > 0) rem_m[k] = rem_m[k] - 1;
            else if (hz) rem_m[k] = lub[k] - 1;
            hist[k][2] = hist[k][1];
            hist[k][1] = hist[k][0];
            hist[k][0] = id;
            hist[k][0].v = id.v && !stl && !fl;
        end
    endtask

    // One cycle with reset asserted; outputs in that cycle are not checked.
    task automatic do_reset(ins_t id);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive_ids(id, 1'b0);
        cyc++;
        model_reset();
    endtask

    // Monitor: pops each expected response when the DUT presents it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.k == 0) begin
                    $display("cyc=%0d L1 a=%b b=%b stall=%b cnt=%0d", e.cyc, fa1, fb1, st1, sc1);
                    chk($sformatf("L1 fwd_a cyc%0d", e.cyc), fa1, e.a);
                    chk($sformatf("L1 fwd_b cyc%0d", e.cyc), fb1, e.b);
                    chk($sformatf("L1 stall cyc%0d", e.cyc), st1, e.s);
                    chk($sformatf("L1 count cyc%0d", e.cyc), sc1, e.c);
                end else begin
                    $display("cyc=%0d L3 a=%b b=%b stall=%b cnt=%0d", e.cyc, fa3, fb3, st3, sc3);
                    chk($sformatf("L3 fwd_a cyc%0d", e.cyc), fa3, e.a);
                    chk($sformatf("L3 fwd_b cyc%0d", e.cyc), fb3, e.b);
                    chk($sformatf("L3 stall cyc%0d", e.cyc), st3, e.s);
                    chk($sformatf("L3 count cyc%0d", e.cyc), sc3, e.c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ins_t r;
        rst_n = 1'b0;
        drive_ids(nop(), 1'b0);
        model_reset();
        do_reset(nop());

        // Reset state.
        step(nop(), 0); #3;
        chk("rst fwd_a", fa1, 0); chk("rst fwd_b", fb1, 0);
        chk("rst stall", st3, 0); chk("rst count", sc3, 0);

        // ADD $3,$1,$2 ; SUB $4,$3,$5
        step(rtype(3, 1, 2), 0); step(rtype(4, 3, 5), 0); step(nop(), 0); #3;
        chk("exmem fwd_a", fa1, 2); chk("exmem fwd_b", fb1, 0); chk("exmem stall", st1, 0);

        // ADD $3 ; NOP ; OR $6,$7,$3
        step(rtype(3, 1, 2), 0); step(nop(), 0); step(rtype(6, 7, 3), 0); step(nop(), 0); #3;
        chk("memwb fwd_b", fb1, 1); chk("memwb fwd_a", fa1, 0);
        // ADD $3 ; ADD $3 ; OR -> youngest wins
        step(rtype(3, 1, 2), 0); step(rtype(3, 4, 5), 0); step(rtype(6, 7, 3), 0); step(nop(), 0); #3;
        chk("prio fwd_b", fb1, 2); chk("prio fwd_a", fa1, 0);

        // LW $8,0($9) ; ADD $10,$8,$1 held in ID while stalled
        do_reset(nop());
        step(lw(8, 9), 0);
        step(rtype(10, 8, 1), 0); #3;
        chk("lu L1 stall1", st1, 1); chk("lu L3 stall1", st3, 1);
        step(rtype(10, 8, 1), 0); #3;
        chk("lu L1 stall2", st1, 0); chk("lu L1 bubble", fa1, 0); chk("lu L3 stall2", st3, 1);
        step(rtype(10, 8, 1), 0); #3;
        chk("lu L1 fwd_a", fa1, 1); chk("lu L1 count", sc1, 1); chk("lu L3 stall3", st3, 1);
        step(rtype(10, 8, 1), 0); #3;
        chk("lu L3 stall4", st3, 0); chk("lu L3 count", sc3, 3); chk("lu L1 count2", sc1, 1);
        step(nop(), 0);

        // Flush in the second stall cycle of the 3-bubble sequence
        do_reset(nop());
        step(lw(8, 9), 0);
        step(rtype(10, 8, 1), 0); #3;
        chk("fl L3 stall1", st3, 1);
        step(rtype(10, 8, 1), 1); #3;
        chk("fl L3 stall", st3, 0); chk("fl L3 count", sc3, 1);
        step(rtype(10, 8, 1), 0); #3;
        chk("fl L3 idle", st3, 0); chk("fl L3 count2", sc3, 1);

        // Register $0 is never a producer
        step(rtype(0, 1, 2), 0); step(rtype(4, 0, 0), 0); step(nop(), 0); #3;
        chk("r0 fwd_a", fa1, 0); chk("r0 fwd_b", fb1, 0); chk("r0 stall", st1, 0);
        step(lw(0, 9), 0); step(rtype(10, 0, 0), 0); #3;
        chk("r0 lu L1 stall", st1, 0); chk("r0 lu L3 stall", st3, 0);
        step(nop(), 0); #3;
        chk("r0 lu fwd_a", fa3, 0); chk("r0 lu fwd_b", fb3, 0);

        // Reset mid-stall with tags in flight
        step(rtype(3, 1, 2), 0); step(lw(8, 9), 0);
        step(rtype(10, 8, 3), 0); step(rtype(10, 8, 3), 0); #3;
        chk("mr L3 stalling", st3, 1);
        do_reset(rtype(10, 8, 3));
        step(rtype(11, 3, 8), 0); #3;
        chk("mr fwd_a", fa3, 0); chk("mr fwd_b", fb3, 0); chk("mr stall", st3, 0);
        chk("mr count L3", sc3, 0); chk("mr count L1", sc1, 0);
        step(nop(), 0); #3;
        chk("mr stale fwd_a", fa1, 0); chk("mr stale fwd_b", fb1, 0);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            r.v    = ($urandom_range(0, 7) != 0);
            r.rs   = int'($urandom_range(0, 7));
            r.rt   = int'($urandom_range(0, 7));
            r.ut   = $urandom_range(0, 1) == 1;
            r.dest = int'($urandom_range(0, 7));
            r.rw   = $urandom_range(0, 3) != 0;
            r.mr   = r.rw && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) do_reset(r);
            else step(r, $urandom_range(0, 9) == 0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
